softmc_instr_arbiter: RTL

Shares the single memory-controller instruction port (app_en/app_ack/app_instr) between NUM_REQ instruction sources, e.g. the PCIe host channel and an on-chip refresh/test sequencer. Arbitration is round-robin at instruction-group granularity. A group is a run of instructions ending with req_last, and it is never interleaved with another source. It sits between the PCIe application bridge (and peer sources) and the MC instruction input.

---
 rtl/softmc_instr_arbiter_pkg.sv | 27 ++
 rtl/softmc_instr_arbiter_if.sv | 38 +++
 rtl/softmc_rr_pick.sv | 30 +++
 rtl/softmc_instr_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/softmc_instr_arbiter_pkg.sv
// Shared types and helpers for the SoftMC instruction arbiter.
// Holds the FSM state encoding and width helpers.
package softmc_arb_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int MAX_REQ     = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width for n requesters, never below one bit.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/softmc_instr_arbiter_if.sv
// Requester-side and MC-side instruction handshakes of the arbiter.
// The slave view belongs to the arbiter, master to its environment.
interface softmc_instr_arbiter_if
  import softmc_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int INSTR_WIDTH = INSTR_W_DEF
);

  logic [NUM_REQ-1:0]             req_en;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ*INSTR_WIDTH-1:0] req_instr;
  logic [NUM_REQ-1:0]             req_ack;
  logic                           app_en;
  logic                           app_ack;
  logic [INSTR_WIDTH-1:0]         app_instr;

  modport slave (
    input  req_en,
    input  req_last,
    input  req_instr,
    input  app_ack,
    output req_ack,
    output app_en,
    output app_instr
  );

  modport master (
    output req_en,
    output req_last,
    output req_instr,
    output app_ack,
    input  req_ack,
    input  app_en,
    input  app_instr
  );

endinterface

// File: rtl/softmc_rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr.
// Rotates a doubled request vector, then finds the lowest set bit.
module softmc_rr_pick
  import softmc_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output logic               found
);

  logic [NUM_REQ-1:0] rot;

  always_comb begin
    rot    = NUM_REQ'({req, req} >> (int'(rr_ptr) + 1));
    found  = 1'b0;
    winner = '0;
    // Scan downward so the lowest set offset wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found  = 1'b1;
        winner = IW'((int'(rr_ptr) + 1 + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/softmc_instr_arbiter.sv
// Round-robin sharing of the MC instruction port between sources.
// Grants are held for a whole group, up to the last-flagged instruction.
module softmc_instr_arbiter
  import softmc_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int INSTR_WIDTH = INSTR_W_DEF,
  parameter int TIMEOUT     = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  softmc_instr_arbiter_if.slave         bus,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IW = id_width(NUM_REQ);

  arb_state_e state_q, state_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [31:0]   stall_q, stall_d;
  logic          terr_q, terr_d;

  logic [IW-1:0] win;
  logic          found;

  logic                   own_en;
  logic                   own_last;
  logic [INSTR_WIDTH-1:0] own_instr;
  logic                   xfer;

  logic [NUM_REQ-1:0]     ack;
  logic                   app_en;
  logic [INSTR_WIDTH-1:0] app_instr;

  softmc_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (bus.req_en),
    .rr_ptr (ptr_q),
    .winner (win),
    .found  (found)
  );

  always_comb begin
    own_en    = bus.req_en[gid_q];
    own_last  = bus.req_last[gid_q];
    own_instr = bus.req_instr[gid_q*INSTR_WIDTH +: INSTR_WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
    stall_d   = stall_q;
    terr_d    = terr_q;
    ack       = '0;
    app_en    = 1'b0;
    app_instr = '0;
    xfer      = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_GRANT;
          gid_d   = win;
          stall_d = '0;
        end
      end
      ARB_GRANT: begin
        app_en     = own_en;
        app_instr  = own_instr;
        ack[gid_q] = bus.app_ack & own_en;
        xfer       = own_en & bus.app_ack;
        // Only owner silence counts; MC backpressure never does.
        stall_d    = own_en ? '0 : stall_q + 32'd1;
        if (xfer && own_last) begin
          state_d = ARB_IDLE;
          ptr_d   = gid_q;
        end else if (TIMEOUT != 0 && !own_en &&
                     stall_q == 32'(TIMEOUT - 1)) begin
          state_d = ARB_IDLE;
          ptr_d   = gid_q;
          terr_d  = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gid_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.req_ack   = ack;
  assign bus.app_en    = app_en;
  assign bus.app_instr = app_instr;
  assign grant_id      = gid_q;
  assign busy          = (state_q == ARB_GRANT);
  assign timeout_err   = terr_q;

endmodule
